ring_counter: RTL and testbench
===============================

RING_COUNTER -- requirements
Module: ring_counter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set ring length in bits (legal range 2..32).
REQ-002 Parameter INIT, default 4'b0001 (bit 0 hot, sized to WIDTH), SHALL be the one-hot reset/seed value.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: one clock, synchronous, active-low.
REQ-005 en  input  1  SHALL advance the ring one position per cycle when 1.
REQ-006 dir  input  1  SHALL select direction: 0 = rotate toward MSB, 1 = rotate toward LSB.
REQ-007 load  input  1  SHALL request loading load_val into Q.
REQ-008 load_val  input  WIDTH  SHALL be the value to load.
REQ-009 Q  output  WIDTH  SHALL be the registered ring state, always exactly one bit set.
REQ-010 pos  output  clog2(WIDTH)  SHALL be the binary index of the hot bit of Q (combinational from Q).
REQ-011 wrap  output  1  SHALL be a registered one-cycle pulse marking the ring wrap-around.
REQ-012 load_err  output  1  SHALL be a registered one-cycle pulse marking an illegal load.

Function
REQ-013 Priority per cycle SHALL be reset > load > en > hold.
REQ-014 With en=1, load=0, dir=0, Q SHALL rotate left one bit: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
REQ-015 With en=1, load=0, dir=1, Q SHALL rotate right one bit: Q <= {Q[0], Q[WIDTH-1:1]}.
REQ-016 With en=0 and load=0, Q SHALL hold its value.
REQ-017 With en held 1 and dir=0 after reset, Q SHALL follow 0001, 0010, 0100, 1000, 0001, ... (period WIDTH cycles).
REQ-018 wrap SHALL be 1 in the cycle after Q moves from bit WIDTH-1 to bit 0 (dir=0), or from bit 0 to bit WIDTH-1 (dir=1); otherwise 0.
REQ-019 With load=1 and load_val one-hot, Q SHALL take load_val next cycle, and load_err SHALL be 0.
REQ-020 With load=1 and load_val not one-hot (zero or multiple bits), Q SHALL take INIT next cycle and load_err SHALL pulse 1 for one cycle.
REQ-021 A load SHALL never assert wrap.
REQ-022 Changing dir mid-sequence SHALL take effect on the same edge, with no lost or extra step.
REQ-023 If Q is ever found not one-hot (e.g. upset), the next enabled or holding cycle SHALL restore INIT.

Reset
REQ-024 While reset=0 at a rising clk edge, Q SHALL become INIT, and wrap and load_err SHALL become 0.
REQ-025 Reset SHALL override load and en in the same cycle.
REQ-026 Reset asserted mid-sequence SHALL restart the sequence from INIT on the first edge after release.
REQ-027 No output SHALL change asynchronously to clk; pos SHALL follow Q combinationally.

Structure
REQ-028 Package ring_counter_pkg SHALL hold the default WIDTH, the default INIT, and a dir encoding constant (DIR_LEFT=0, DIR_RIGHT=1).
REQ-029 Sub-module onehot_check SHALL provide a one-hot validity flag and a binary index encoder; it SHALL be instantiated for both load_val and Q.
REQ-030 The top SHALL contain only the Q, wrap and load_err registers and their next-state logic.

Verification
REQ-031 reset=0 for 2 cycles, then reset=1 with en=1, dir=0 -> Q = 0001, 0010, 0100, 1000, 0001; wrap=1 only in the cycle Q returns to 0001.
REQ-032 Q=0100, dir=1, en=1 -> Q = 0010, 0001, 1000; wrap pulses with 1000; pos = 1, 0, 3.
REQ-033 load=1 with load_val=0100 -> Q=0100, load_err=0; load=1 with load_val=0110 -> Q=0001, load_err=1 for exactly one cycle.
REQ-034 reset=0, load=1 and en=1 in the same cycle -> Q=0001, wrap=0, load_err=0.
REQ-035 en=0 for 5 cycles at Q=1000 -> Q stays 1000, wrap=0; en=1 then gives Q=0001 and wrap=1.
REQ-036 Every cycle of a random en/dir/load run -> Q has exactly one bit set and pos matches it.

Source files
------------

// File: rtl/ring_counter_pkg.sv
// Shared defaults and direction encoding for the ring counter.
package ring_counter_pkg;

  localparam int RC_WIDTH = 4;
  localparam logic [3:0] RC_INIT = 4'b0001;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage : ring_counter_pkg

// File: rtl/ring_counter_onehot_check.sv
// One-hot validity flag plus binary index of the hot bit.
module onehot_check #(
  parameter int WIDTH = 4,
  parameter int PW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic             valid,
  output logic [PW-1:0]    idx
);

  // Exactly one bit set: nonzero, and clearing the lowest set bit leaves zero.
  assign valid = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

  // OR of the indices of all set bits; exact whenever vec is one-hot.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = idx | PW'(i);
    end
  end

endmodule : onehot_check

// File: rtl/ring_counter.sv
// One-hot ring counter with direction control, checked load, and wrap pulse.
module ring_counter
  import ring_counter_pkg::*;
#(
  parameter int               WIDTH = RC_WIDTH,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(RC_INIT),
  parameter int               PW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic [PW-1:0]    pos,
  output logic             wrap,
  output logic             load_err
);

  logic [WIDTH-1:0] q_p1;
  logic             wrap_p1;
  logic             load_err_p1;

  logic             lv_ok;
  logic [PW-1:0]    lv_idx;
  logic             q_ok;

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             load_err_nxt;

  onehot_check #(.WIDTH(WIDTH), .PW(PW)) u_chk_load (
    .vec   (load_val),
    .valid (lv_ok),
    .idx   (lv_idx)
  );

  onehot_check #(.WIDTH(WIDTH), .PW(PW)) u_chk_q (
    .vec   (q_p1),
    .valid (q_ok),
    .idx   (pos)
  );

  // A corrupted ring is re-seeded before any rotation is attempted.
  always_comb begin
    q_nxt        = q_p1;
    wrap_nxt     = 1'b0;
    load_err_nxt = 1'b0;
    if (load) begin
      if (lv_ok) begin
        q_nxt = WIDTH'(1) << lv_idx;
      end else begin
        q_nxt        = INIT;
        load_err_nxt = 1'b1;
      end
    end else if (!q_ok) begin
      q_nxt = INIT;
    end else if (en) begin
      if (dir == DIR_LEFT) begin
        q_nxt    = {q_p1[WIDTH-2:0], q_p1[WIDTH-1]};
        wrap_nxt = q_p1[WIDTH-1];
      end else begin
        q_nxt    = {q_p1[0], q_p1[WIDTH-1:1]};
        wrap_nxt = q_p1[0];
      end
    end
  end

  // ---- stage p1: registered state and pulses ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_p1        <= INIT;
      wrap_p1     <= 1'b0;
      load_err_p1 <= 1'b0;
    end else begin
      q_p1        <= q_nxt;
      wrap_p1     <= wrap_nxt;
      load_err_p1 <= load_err_nxt;
    end
  end

  assign Q        = q_p1;
  assign wrap     = wrap_p1;
  assign load_err = load_err_p1;

endmodule : ring_counter

// File: tb/tb_ring_counter.sv
// Directed and randomized checks of ring_counter at WIDTH=4.
module tb_ring_counter;

  localparam int W  = 4;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          dir;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  Q;
  logic [PW-1:0] pos;
  logic          wrap;
  logic          load_err;

  int n_tests = 0;
  int n_fail  = 0;

  ring_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .Q        (Q),
    .pos      (pos),
    .wrap     (wrap),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] eq, input int ep,
                         input logic ew, input logic ee);
    chk({tag, ".Q"}, 32'(Q), 32'(eq));
    chk({tag, ".pos"}, 32'(pos), 32'(ep));
    chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
    chk({tag, ".err"}, 32'(load_err), 32'(ee));
  endtask

  logic [W-1:0] mq;
  logic         mw;
  logic         me;
  int           mp;

  initial begin
    reset = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
    step(); step();
    chk_all("reset", 4'b0001, 0, 1'b0, 1'b0);

    reset = 1'b1; en = 1'b1; dir = 1'b0;
    step(); chk_all("left1", 4'b0010, 1, 1'b0, 1'b0);
    step(); chk_all("left2", 4'b0100, 2, 1'b0, 1'b0);
    step(); chk_all("left3", 4'b1000, 3, 1'b0, 1'b0);
    step(); chk_all("left4", 4'b0001, 0, 1'b1, 1'b0);
    step(); chk_all("left5", 4'b0010, 1, 1'b0, 1'b0);

    en = 1'b0; load = 1'b1; load_val = 4'b0100;
    step(); chk_all("load_ok", 4'b0100, 2, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1; dir = 1'b1;
    step(); chk_all("right1", 4'b0010, 1, 1'b0, 1'b0);
    step(); chk_all("right2", 4'b0001, 0, 1'b0, 1'b0);
    step(); chk_all("right3", 4'b1000, 3, 1'b1, 1'b0);

    en = 1'b0; load = 1'b1; load_val = 4'b0110;
    step(); chk_all("load_bad", 4'b0001, 0, 1'b0, 1'b1);
    load = 1'b0;
    step(); chk_all("err_clear", 4'b0001, 0, 1'b0, 1'b0);
    load = 1'b1; load_val = 4'b0000;
    step(); chk_all("load_zero", 4'b0001, 0, 1'b0, 1'b1);

    load_val = 4'b0100;
    step(); chk_all("load_4", 4'b0100, 2, 1'b0, 1'b0);
    reset = 1'b0; load = 1'b1; load_val = 4'b0110; en = 1'b1;
    step(); chk_all("rst_over", 4'b0001, 0, 1'b0, 1'b0);
    reset = 1'b1;

    load = 1'b1; load_val = 4'b1000; en = 1'b0;
    step(); chk_all("load_8", 4'b1000, 3, 1'b0, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); chk_all("hold", 4'b1000, 3, 1'b0, 1'b0);
    end
    en = 1'b1; dir = 1'b0;
    step(); chk_all("hold_wrap", 4'b0001, 0, 1'b1, 1'b0);

    step(); chk_all("dirchg0", 4'b0010, 1, 1'b0, 1'b0);
    dir = 1'b1;
    step(); chk_all("dirchg1", 4'b0001, 0, 1'b0, 1'b0);
    step(); chk_all("dirchg2", 4'b1000, 3, 1'b1, 1'b0);

    dir = 1'b0; load = 1'b1; load_val = 4'b0001;
    step(); chk_all("load_nowrap", 4'b0001, 0, 1'b0, 1'b0);
    load = 1'b0;

    reset = 1'b0;
    step();
    reset = 1'b1;
    mq = 4'b0001; mw = 1'b0; me = 1'b0;
    for (int c = 0; c < 300; c++) begin
      en       = 1'($urandom_range(0, 3) != 0);
      dir      = 1'($urandom_range(0, 1));
      load     = 1'($urandom_range(0, 7) == 0);
      load_val = 4'($urandom_range(0, 15));
      mw = 1'b0; me = 1'b0;
      if (load) begin
        if (load_val == 4'b0001 || load_val == 4'b0010 ||
            load_val == 4'b0100 || load_val == 4'b1000) begin
          mq = load_val;
        end else begin
          mq = 4'b0001; me = 1'b1;
        end
      end else if (en) begin
        if (!dir) begin
          mw = (mq == 4'b1000);
          mq = (mq == 4'b1000) ? 4'b0001 : (mq << 1);
        end else begin
          mw = (mq == 4'b0001);
          mq = (mq == 4'b0001) ? 4'b1000 : (mq >> 1);
        end
      end
      mp = (mq == 4'b0010) ? 1 : (mq == 4'b0100) ? 2 : (mq == 4'b1000) ? 3 : 0;
      step();
      chk_all("rand", mq, mp, mw, me);
      chk("rand.onehot", 32'($countones(Q)), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ring_counter
